// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared sizes and word-packing widths for the input conditioner.
package input_conditioner_pkg;
    localparam int NUM_SW = 5;
    localparam int NUM_BTN = 4;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int WORD_W = 32;
    localparam int SW_PAD = WORD_W - NUM_SW;
    localparam int BTN_PAD = WORD_W - 2 * NUM_BTN;
    localparam int NUM_BITS = 2 * NUM_SW + NUM_BTN;
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: two-flop synchronizer plus mismatch counter and stable register for one raw bit.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic nxt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic mism, done;
    assign mism = sync[1] != stable;
    assign done = mism && cnt == LAST;
    // nxt is the value stable takes on the coming edge; the top uses it to align press pulses
    assign nxt = done ? sync[1] : stable;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            cnt <= (mism && !done) ? cnt + 1'b1 : '0;
            stable <= nxt;
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces switch banks and buttons into processor input words,
// with per-button press pulses and sticky press flags.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SW-1:0]   in0_switches,
    input  logic [NUM_SW-1:0]   in1_switches,
    input  logic [NUM_BTN-1:0]  buttons,
    input  logic [NUM_BTN-1:0]  btn_clr,
    output logic [WORD_W-1:0]   in0,
    output logic [WORD_W-1:0]   in1,
    output logic [WORD_W-1:0]   in2,
    output logic [NUM_BTN-1:0]  btn_press
);
    logic [1:0] rst_pipe;
    logic rst_i;
    logic [NUM_BITS-1:0] raw, stable, nxt;
    logic [NUM_BTN-1:0] rise, btn_pressed;
    logic unused_sw_nxt;
    // assertion is immediate, release waits two clean edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_pipe <= 2'b11;
        else rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst_i = rst_pipe[1];
    assign raw = {buttons, in1_switches, in0_switches};
    for (genvar i = 0; i < NUM_BITS; i++) begin : g_db
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk),
            .rst(rst_i),
            .raw(raw[i]),
            .stable(stable[i]),
            .nxt(nxt[i])
        );
    end
    assign unused_sw_nxt = ^nxt[2*NUM_SW-1:0];
    assign rise = nxt[NUM_BITS-1:2*NUM_SW] & ~stable[NUM_BITS-1:2*NUM_SW];
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            btn_press <= '0;
            btn_pressed <= '0;
        end else begin
            btn_press <= rise;
            btn_pressed <= (btn_pressed & ~btn_clr) | rise;
        end
    end
    assign in0 = {{SW_PAD{1'b0}}, stable[NUM_SW-1:0]};
    assign in1 = {{SW_PAD{1'b0}}, stable[2*NUM_SW-1:NUM_SW]};
    assign in2 = {{BTN_PAD{1'b0}}, btn_pressed, stable[NUM_BITS-1:2*NUM_SW]};
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed stimulus scored against a history-window reference model.
module tb_input_conditioner;
    localparam int D = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] sw0 = '0, sw1 = '0;
    logic [3:0] btn = '0, clr = '0;
    logic [31:0] in0, in1, in2;
    logic [3:0] btn_press;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .in0_switches(sw0), .in1_switches(sw1),
        .buttons(btn), .btn_clr(clr), .in0(in0), .in1(in1), .in2(in2), .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] i0, i1, i2;
        logic [3:0]  bp;
    } exp_t;

    exp_t exq[$];
    int n_cmp = 0, n_bad = 0;
    bit hist[14][$];
    bit stab[14];
    logic [3:0] m_pressed, m_press;
    int rel = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int b = 0; b < 14; b++) begin
            hist[b].delete();
            repeat (D + 2) hist[b].push_back(1'b0);
            stab[b] = 1'b0;
        end
        m_pressed = '0;
        m_press = '0;
    endfunction

    // A bit flips when the synchronized samples seen on the last D edges all disagree with it;
    // the sample evaluated at edge n is the raw value captured at edge n-2.
    function automatic void m_edge(input logic [13:0] raw, input logic [3:0] c, input logic r);
        logic [3:0] rose;
        bit flip;
        rose = '0;
        if (r) begin
            rel = 0;
            m_reset();
            return;
        end
        rel++;
        if (rel <= 2) begin
            m_reset();
            return;
        end
        for (int b = 0; b < 14; b++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[b][hist[b].size() - 2 - j] == stab[b]) flip = 1'b0;
            if (flip) begin
                stab[b] = !stab[b];
                if (b >= 10 && stab[b]) rose[b-10] = 1'b1;
            end
            hist[b].push_back(raw[b]);
            void'(hist[b].pop_front());
        end
        m_press = rose;
        m_pressed = (m_pressed & ~c) | rose;
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e = '0;
        for (int b = 0; b < 5; b++) begin
            e.i0[b] = stab[b];
            e.i1[b] = stab[b+5];
        end
        for (int b = 0; b < 4; b++) e.i2[b] = stab[b+10];
        e.i2[7:4] = m_pressed;
        e.bp = m_press;
        return e;
    endfunction

    task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [3:0] k,
                        input logic [3:0] c, input logic r);
        @(negedge clk);
        #1;
        sw0 = a; sw1 = b; btn = k; clr = c; rst = r;
        if (r) begin
            #1;
            chk("imm_rst", in0 | in1 | in2 | {28'b0, btn_press}, 32'h0);
        end
        @(posedge clk);
        m_edge({k, b, a}, c, r);
        exq.push_back(m_out());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("in0", in0, e.i0);
                chk("in1", in1, e.i1);
                chk("in2", in2, e.i2);
                chk("btn_press", {28'b0, btn_press}, {28'b0, e.bp});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [4:0] a, b;
        logic [3:0] k, c;
        m_reset();
        repeat (2) step(5'h00, 5'h00, 4'h0, 4'h0, 1'b1);
        repeat (4) step(5'h00, 5'h00, 4'h0, 4'h0, 1'b0);
        repeat (D + 4) step(5'h15, 5'h00, 4'h0, 4'h0, 1'b0);
        repeat (3) step(5'h15, 5'h00, 4'h4, 4'h0, 1'b0);
        repeat (D + 4) step(5'h15, 5'h00, 4'h0, 4'h0, 1'b0);
        repeat (D + 4) step(5'h15, 5'h00, 4'h1, 4'h0, 1'b0);
        repeat (D + 4) step(5'h15, 5'h00, 4'h0, 4'h0, 1'b0);
        repeat (D + 1) step(5'h15, 5'h00, 4'h1, 4'h0, 1'b0);
        step(5'h15, 5'h00, 4'h1, 4'h1, 1'b0);
        repeat (3) step(5'h15, 5'h00, 4'h1, 4'h0, 1'b0);
        step(5'h15, 5'h00, 4'h1, 4'h1, 1'b0);
        repeat (3) step(5'h15, 5'h00, 4'h1, 4'h0, 1'b0);
        repeat (4) step(5'h15, 5'h1F, 4'h1, 4'h0, 1'b0);
        step(5'h15, 5'h1F, 4'h1, 4'h0, 1'b1);
        repeat (D + 8) step(5'h15, 5'h1F, 4'h1, 4'h0, 1'b0);
        repeat (D + 4) step(5'h0A, 5'h00, 4'hE, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++)
            step((i % 2) ? 5'h1F : 5'h00, (i % 2) ? 5'h00 : 5'h1F, (i % 2) ? 4'h0 : 4'hF, 4'h0, 1'b0);
        repeat (D + 4) step(5'h00, 5'h1F, 4'hF, 4'h0, 1'b0);
        for (int s = 0; s < 120; s++) begin
            a = 5'($urandom); b = 5'($urandom); k = 4'($urandom);
            for (int h = $urandom_range(1, D + 3); h > 0; h--) begin
                c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                step(a, b, k, c, $urandom_range(0, 79) == 0);
            end
        end
        repeat (3) @(negedge clk);
        chk("drain", 32'(exq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16; consecutive synchronized cycles a raw input must differ from its stable value before the stable value updates; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in0_switches  input  5  raw, asynchronous switch bank 0.
REQ-005 Port: in1_switches  input  5  raw, asynchronous switch bank 1.
REQ-006 Port: buttons  input  4  raw, asynchronous push buttons, 1 = pressed.
REQ-007 Port: btn_clr  input  4  per-bit clear of the sticky press flags, synchronous to clk.
REQ-008 Port: in0  output  32  processor input word 0, {27'b0, debounced in0_switches}.
REQ-009 Port: in1  output  32  processor input word 1, {27'b0, debounced in1_switches}.
REQ-010 Port: in2  output  32  processor input word 2, {24'b0, btn_pressed[3:0], debounced buttons[3:0]}.
REQ-011 Port: btn_press  output  4  one-cycle pulse per button on a debounced 0->1 transition.

Function
REQ-012 Each of the 14 raw bits SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-013 Each bit SHALL hold a stable value and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-014 If the synchronized value equals stable, the counter SHALL be cleared to 0.
REQ-015 If the synchronized value differs from stable and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 If the synchronized value differs from stable and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear to 0 on that edge.
REQ-017 Latency: a raw change held steady SHALL appear on in0/in1/in2 exactly DEBOUNCE_CYCLES+1 rising edges after the first edge that samples it into the synchronizer.
REQ-018 A raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change stable; the counter restarts from 0 on the next mismatch.
REQ-019 btn_press[i] SHALL be 1 for exactly the one cycle following the edge on which stable button i goes 0->1, and 0 otherwise; a 1->0 transition SHALL produce no pulse.
REQ-020 btn_pressed[i] SHALL set on the same edge that raises btn_press[i], and SHALL clear when btn_clr[i]=1 is sampled.
REQ-021 If set and clear coincide on one edge, btn_pressed[i] SHALL remain or become 1 (set wins).
REQ-022 Bits SHALL be fully independent; simultaneous changes on any subset SHALL each follow REQ-014..REQ-021 without interaction.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 While rst=1, all synchronizer flops, stable values, counters, btn_pressed and the btn_press registers SHALL be 0, so in0=in1=in2=0 and btn_press=0.
REQ-025 Reset asserted mid-debounce SHALL discard partial counts; after release, inputs that are already high SHALL still require the full REQ-017 latency.
REQ-026 Reset release SHALL be synchronized to clk internally, with deassertion synchronous to clk and assertion asynchronous.

Structure
REQ-027 Package input_conditioner_pkg SHALL define NUM_SW=5, NUM_BTN=4, the default DEBOUNCE_CYCLES and the 32-bit word-packing widths.
REQ-028 A sub-module debounce_bit (synchronizer, counter and stable register for one bit, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated 14 times; edge detection and the sticky logic stay in the top module.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Bench: in0_switches 00000->10101 held -> in0 = 0x00000015 exactly 5 edges after the first sampling edge, and in0 = 0 on the edge before.
REQ-030 Bench: buttons[2] high for 3 cycles then low -> in2 stays 0 and btn_press stays 0.
REQ-031 Bench: buttons[0] held high -> in2 = 0x00000011, btn_press = 0001 for exactly one cycle; release -> in2 = 0x00000010, with no pulse.
REQ-032 Bench: btn_clr[0]=1 on the same edge as a new press of button 0 -> btn_pressed[0] remains 1; btn_clr[0]=1 alone -> in2[4] = 0 on the next cycle.
REQ-033 Bench: in1_switches = 11111 and rst asserted for 1 cycle at debounce count 2 -> in1 = 0 immediately; in1 = 0x0000001F only after the full latency counted from release.
REQ-034 Bench: all 14 inputs toggle simultaneously -> all outputs update on the same edge; the raw input alternating every cycle -> no output change.
